// File: rtl/mc_control_unit.sv
// Multicycle control FSM for an RV32I subset (lw, sw, add/sub/and/or, addi/andi/ori, beq, jal).
// Sequences a shared-memory datapath, drives every mux select and write enable, halts on illegal encodings.
module mc_control_unit #(
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Run,
  input  logic [width-1:0] Instr,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             Retire,
  output logic             Illegal,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q;
  state_t     state_d;
  logic       illegal_q;

  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f3_alu_ok;
  logic       f7_ok;
  logic       en;

  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       retire_raw;
  logic [1:0] alu_decode;

  logic       unused_instr;

  assign op     = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[31:25];
  assign unused_instr = ^Instr;

  assign f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign f7_ok     = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && (funct3 == 3'b000));

  // Enables are suppressed while frozen or in reset; mux selects are not.
  assign en = Run && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else if (Run) begin
      state_q <= state_d;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_ILLEGAL;
        case (op)
          OP_LW, OP_SW: if (funct3 == 3'b010) state_d = S_MEMADR;
          OP_R:         if (f3_alu_ok && f7_ok) state_d = S_EXECUTER;
          OP_I:         if (f3_alu_ok) state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       if (funct3 == 3'b000) state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Subtract only for R-type with funct7[5]; addi never subtracts.
  always_comb begin
    alu_decode = 2'b00;
    case (funct3)
      3'b000:  alu_decode = (op[5] && funct7[5]) ? 2'b01 : 2'b00;
      3'b110:  alu_decode = 2'b11;
      3'b111:  alu_decode = 2'b10;
      default: alu_decode = 2'b00;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_decode;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA      = 2'b10;
        ALUControl   = 2'b01;
        pc_write_raw = Zero;
        retire_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite  = pc_write_raw  && en;
  assign MemWrite = mem_write_raw && en;
  assign IRWrite  = ir_write_raw  && en;
  assign RegWrite = reg_write_raw && en;
  assign Retire   = retire_raw    && en;
  assign Illegal  = illegal_q;
  assign State    = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle
// against hand-computed state and control words.
module tb_mc_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Run;
  logic [31:0] Instr;
  logic        Zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc;
  logic [3:0]  State;

  int n_cmp = 0;
  int n_bad = 0;

  mc_control_unit #(.width(32)) dut (
    .CLK(CLK), .RST(RST), .Run(Run), .Instr(Instr), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .Retire(Retire), .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,Retire}
  function automatic logic [15:0] cw(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] alu, input logic [1:0] imm,
                                     input logic rw, input logic ret);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret};
  endfunction

  // Check current cycle, then advance one clock edge and settle.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] w, input logic ill);
    logic [15:0] obs;
    #1;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, Retire};
    check({tag, ".state"}, {28'd0, State}, {28'd0, st});
    check({tag, ".ctrl"}, {16'd0, obs}, {16'd0, w});
    check({tag, ".illegal"}, {31'd0, Illegal}, {31'd0, ill});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; Run = 1'b1; Zero = 1'b0; Instr = 32'h00402083;
    @(posedge CLK); #1;
    // Reset held: FETCH selects visible, enables suppressed
    cyc("rst", 4'd0, cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    RST = 1'b0;

    // lw x1,4(x0)
    cyc("lw.fetch",   4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    cyc("lw.decode",  4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0), 1'b0);
    cyc("lw.memadr",  4'd2, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0), 1'b0);
    cyc("lw.memread", 4'd3, cw(0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0), 1'b0);
    cyc("lw.memwb",   4'd4, cw(0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b00,1,1), 1'b0);

    // sw x1,8(x0)
    Instr = 32'h00102423;
    cyc("sw.fetch",    4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b01,0,0), 1'b0);
    cyc("sw.decode",   4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0,0), 1'b0);
    cyc("sw.memadr",   4'd2, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0), 1'b0);
    cyc("sw.memwrite", 4'd5, cw(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,1), 1'b0);

    // sub x3,x1,x2
    Instr = 32'h402081B3;
    cyc("sub.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    cyc("sub.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0), 1'b0);
    cyc("sub.exec",   4'd6, cw(0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b00,0,0), 1'b0);
    cyc("sub.aluwb",  4'd7, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1), 1'b0);

    // or x3,x1,x2
    Instr = 32'h0020E1B3;
    cyc("or.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    cyc("or.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0), 1'b0);
    cyc("or.exec",   4'd6, cw(0,0,0,0,2'b00,2'b10,2'b00,2'b11,2'b00,0,0), 1'b0);
    cyc("or.aluwb",  4'd7, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1), 1'b0);

    // beq taken
    Instr = 32'h00208463; Zero = 1'b1;
    cyc("beq1.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b10,0,0), 1'b0);
    cyc("beq1.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0), 1'b0);
    cyc("beq1.beq",    4'd10, cw(1,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1), 1'b0);

    // beq not taken
    Zero = 1'b0;
    cyc("beq0.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b10,0,0), 1'b0);
    cyc("beq0.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0), 1'b0);
    cyc("beq0.beq",    4'd10, cw(0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1), 1'b0);

    // jal x1, 0
    Instr = 32'h000000EF;
    cyc("jal.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b11,0,0), 1'b0);
    cyc("jal.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0,0), 1'b0);
    cyc("jal.jal",    4'd9, cw(1,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0,0), 1'b0);
    cyc("jal.aluwb",  4'd7, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b11,1,1), 1'b0);

    // ecall is unsupported: sticky halt
    Instr = 32'h00000073;
    cyc("ill.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    cyc("ill.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("ill.hold", 4'd11, 16'd0, 1'b1);
    RST = 1'b1;
    cyc("ill.rst", 4'd11, 16'd0, 1'b1);
    RST = 1'b0;

    // addi x1,x0,5 with Run stalls in EXECUTEI and ALUWB
    Instr = 32'h00500093;
    cyc("addi.fetch",  4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    cyc("addi.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0), 1'b0);
    Run = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("addi.stall", 4'd8, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0), 1'b0);
    Run = 1'b1;
    cyc("addi.exec",   4'd8, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0), 1'b0);
    Run = 1'b0;
    cyc("addi.wbstall", 4'd7, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0), 1'b0);
    Run = 1'b1;
    cyc("addi.aluwb",  4'd7, cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1), 1'b0);

    // Frozen FETCH suppresses PC/IR loads; then resume
    Run = 1'b0;
    cyc("fetch.stall", 4'd0, cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    Run = 1'b1;
    cyc("fetch.run",   4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);
    cyc("after.decode", 4'd1, cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0), 1'b0);

    // Reset mid-instruction returns to FETCH
    RST = 1'b1;
    cyc("mid.rst", 4'd8, cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0), 1'b0);
    RST = 1'b0;
    cyc("mid.fetch", 4'd0, cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control FSM for the RV32I subset (lw, sw, add/sub/and/or, addi/andi/ori, beq, jal) that sequences a shared-memory, multicycle variant of the core datapath. It sits beside that datapath in place of the single-cycle control unit. It decodes the latched instruction register and steps one instruction through 3–5 cycles, driving every mux select and write enable. It also flags unsupported encodings and halts on them.

## Interface
- width, 32, width of Instr
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- Run  in  1  advance enable; low freezes the FSM
- Instr  in  width  IR contents; uses [6:0] op, [14:12] funct3, [31:25] funct7
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register load
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A register
- ALUSrcB  out  2  00 WriteData register, 01 ImmExt, 10 constant 4
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 or
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register-file write
- Retire  out  1  last cycle of an instruction
- Illegal  out  1  sticky unsupported-instruction flag
- State  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, ILLEGAL 11. Codes 12–15 go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, JAL, BEQ, or ILLEGAL.
  - MEMADR→MEMREAD for lw (op 0000011), MEMWRITE for sw (op 0100011).
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECUTER→ALUWB. EXECUTEI→ALUWB. JAL→ALUWB. ALUWB→FETCH.
  - BEQ→FETCH. ILLEGAL→ILLEGAL until RST.
- Legal encodings, checked in DECODE:
  - lw/sw require funct3 010; beq (1100011) requires 000; jal (1101111) has no funct3 check.
  - R-type (0110011) and I-ALU (0010011) require funct3 ∈ {000, 110, 111}.
  - R-type funct7 must be 0000000, or 0100000 only with funct3 000.
  - Any other combination goes to ILLEGAL.
- Per-state asserted outputs; anything unlisted is 0 or 00:
  - FETCH: IRWrite, ALUSrcB=10, ResultSrc=10, PCWrite, add.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite, Retire.
  - MEMWRITE: AdrSrc=1, MemWrite, Retire.
  - EXECUTER / EXECUTEI: ALUSrcA=10, ALUSrcB=00 / 01, ALU decode.
  - ALUWB: RegWrite, Retire.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCWrite, add.
  - BEQ: ALUSrcA=10, sub, PCWrite=Zero, Retire.
  - ILLEGAL: none.
- ALU decode (EXECUTER/EXECUTEI):
  - funct3 000 gives sub when op[5]=1 and funct7[5]=1, else add.
  - funct3 110 gives or; 111 gives and.
- ImmSrc is combinational from op in every state: sw→01, beq→10, jal→11, else 00.
- Run=0: state holds. PCWrite, IRWrite, RegWrite, MemWrite and Retire are forced 0. Mux selects keep their state values.

## Timing
- Outputs are combinational from the state register and Instr. The state updates on the CLK rising edge when Run=1.
- Cycles per instruction (FETCH through Retire):
  - lw 5.
  - sw, R-type, I-ALU, jal 4.
  - beq 3.
- Retire is high for exactly one cycle per instruction while Run=1.
- Reset:
  - RST high at a clock edge sets state to FETCH and clears Illegal.
  - While RST is high, all write enables and Retire are forced 0.
  - RST has priority over Run and over any state, including mid-instruction and ILLEGAL.
- Illegal rises on the edge that enters ILLEGAL and stays high until reset.
- A Run deassertion mid-instruction stretches that state. No enable is lost or repeated after Run returns.

## Test plan
- Reset, then lw x1,4(x0) (0x00402083) with Run=1 -> states 0,1,2,3,4. RegWrite only in state 4 with ResultSrc=01; Retire exactly once.
- sw x1,8(x0) (0x00102423) -> states 0,1,2,5. MemWrite=1 and AdrSrc=1 only in state 5; ImmSrc=01 throughout; RegWrite never asserted.
- sub x3,x1,x2 (0x402081B3) then or x3,x1,x2 (0x0020E1B3) -> ALUControl=01 then 11 in state 6, and RegWrite in state 7.
- beq (0x00208463) with Zero=1, then with Zero=0 -> PCWrite=1 in BEQ only in the Zero=1 case; 3 cycles each.
- Instr=0x00000073 -> Illegal=1 from cycle 3 and the state sticks at 11. Pulsing RST for one cycle -> state 0, Illegal=0.
- addi (0x00500093), with Run held low for 3 cycles in EXECUTEI -> state stays 8 and enables stay 0. After Run returns, the instruction completes through ALUWB with one Retire.
